// File: rtl/fx_bus_arb_if.sv
// Per-master request/response channel between one fx bus master and fx_bus_arb.
interface fx_bus_arb_if #(
  parameter int unsigned LEN_W = 4
);
  logic             req;
  logic             we;
  logic [21:0]      addr;
  logic [LEN_W-1:0] len;
  logic [7:0]       wdata;
  logic             gnt;
  logic             wack;
  logic [7:0]       rdata;
  logic             rvalid;
  logic             done;

  modport master (
    output req, we, addr, len, wdata,
    input  gnt, wack, rdata, rvalid, done
  );

  modport slave (
    input  req, we, addr, len, wdata,
    output gnt, wack, rdata, rvalid, done
  );
endinterface

// File: rtl/fx_bus_arb.sv
// Two-master round-robin arbiter and burst sequencer for the fx register bus.
// Each granted burst becomes per-byte fx_wr/fx_rd cycles with an auto-incrementing offset.
module fx_bus_arb #(
  parameter int unsigned LEN_W = 4
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  fx_bus_arb_if.slave m0,
  fx_bus_arb_if.slave m1,
  output logic        fx_wr,
  output logic        fx_rd,
  output logic [21:0] fx_waddr,
  output logic [21:0] fx_raddr,
  output logic [7:0]  fx_data,
  input  logic [7:0]  fx_q,
  output logic        bus_busy
);

  typedef enum logic [1:0] {StIdle, StWr, StRd, StDrain} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [21:0]      addr_q, addr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       wack_q, wack_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0]       done_q, done_d;
  logic [7:0]       rdata0_q, rdata0_d;
  logic [7:0]       rdata1_q, rdata1_d;
  logic             fx_wr_q, fx_wr_d;
  logic             fx_rd_q, fx_rd_d;
  logic [21:0]      fx_waddr_q, fx_waddr_d;
  logic [21:0]      fx_raddr_q, fx_raddr_d;
  logic [7:0]       fx_data_q, fx_data_d;
  logic             rd_last_q, rd_last_d;
  logic             rd_dly_q, rd_last_dly_q;
  logic             busy_q;

  logic             win;
  logic [7:0]       wdata_sel;
  logic [21:0]      addr_inc;

  // On contention the master not granted last wins; last_q resets to m1 so m0 wins first.
  assign win       = (m0.req && m1.req) ? ~last_q : m1.req;
  assign wdata_sel = owner_q ? m1.wdata : m0.wdata;
  assign addr_inc  = {addr_q[21:16], addr_q[15:0] + 16'd1};

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    gnt_d      = '0;
    wack_d     = '0;
    rvalid_d   = '0;
    done_d     = '0;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    fx_wr_d    = 1'b0;
    fx_rd_d    = 1'b0;
    fx_waddr_d = fx_waddr_q;
    fx_raddr_d = fx_raddr_q;
    fx_data_d  = fx_data_q;
    rd_last_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (m0.req || m1.req) begin
          owner_d     = win;
          last_d      = win;
          addr_d      = win ? m1.addr : m0.addr;
          cnt_d       = win ? m1.len : m0.len;
          gnt_d[win]  = 1'b1;
          if (win ? m1.we : m0.we) begin
            wack_d[win] = 1'b1;
            state_d     = StWr;
          end else begin
            state_d     = StRd;
          end
        end
      end
      StWr: begin
        fx_wr_d    = 1'b1;
        fx_waddr_d = addr_q;
        fx_data_d  = wdata_sel;
        addr_d     = addr_inc;
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == '0) begin
          done_d[owner_q] = 1'b1;
          state_d         = StDrain;
        end else begin
          wack_d[owner_q] = 1'b1;
        end
      end
      StRd: begin
        fx_rd_d    = 1'b1;
        fx_raddr_d = addr_q;
        addr_d     = addr_inc;
        cnt_d      = cnt_q - LEN_W'(1);
        if (cnt_q == '0) begin
          rd_last_d = 1'b1;
          state_d   = StDrain;
        end
      end
      StDrain: begin
        // Leave once the done pulse is on the outputs.
        if (done_q != '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Slaves answer one cycle after fx_rd; capture that reply for the owner.
    if (rd_dly_q) begin
      rvalid_d[owner_q] = 1'b1;
      if (rd_last_dly_q) done_d[owner_q] = 1'b1;
      if (owner_q) rdata1_d = fx_q;
      else         rdata0_d = fx_q;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      addr_q        <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      wack_q        <= '0;
      rvalid_q      <= '0;
      done_q        <= '0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      fx_wr_q       <= 1'b0;
      fx_rd_q       <= 1'b0;
      fx_waddr_q    <= '0;
      fx_raddr_q    <= '0;
      fx_data_q     <= '0;
      rd_last_q     <= 1'b0;
      rd_dly_q      <= 1'b0;
      rd_last_dly_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      wack_q        <= wack_d;
      rvalid_q      <= rvalid_d;
      done_q        <= done_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      fx_wr_q       <= fx_wr_d;
      fx_rd_q       <= fx_rd_d;
      fx_waddr_q    <= fx_waddr_d;
      fx_raddr_q    <= fx_raddr_d;
      fx_data_q     <= fx_data_d;
      rd_last_q     <= rd_last_d;
      rd_dly_q      <= fx_rd_q;
      rd_last_dly_q <= rd_last_q;
      busy_q        <= (state_d != StIdle);
    end
  end

  assign m0.gnt    = gnt_q[0];
  assign m1.gnt    = gnt_q[1];
  assign m0.wack   = wack_q[0];
  assign m1.wack   = wack_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.done   = done_q[0];
  assign m1.done   = done_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;
  assign fx_wr     = fx_wr_q;
  assign fx_rd     = fx_rd_q;
  assign fx_waddr  = fx_waddr_q;
  assign fx_raddr  = fx_raddr_q;
  assign fx_data   = fx_data_q;
  assign bus_busy  = busy_q;

endmodule

// File: tb/tb_fx_bus_arb.sv
// Randomized bench for fx_bus_arb: a burst-level timing/address/data model plus
// a device-1 slave whose registers start at (offset[7:0] ^ 0x01).
module tb_fx_bus_arb;
  localparam int unsigned LenW = 4;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        fx_wr, fx_rd, bus_busy;
  logic [21:0] fx_waddr, fx_raddr;
  logic [7:0]  fx_data, fx_q;

  always #5 clk_sys = ~clk_sys;

  fx_bus_arb_if #(.LEN_W(LenW)) m0_if ();
  fx_bus_arb_if #(.LEN_W(LenW)) m1_if ();

  fx_bus_arb #(.LEN_W(LenW)) dut (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .m0       (m0_if),
    .m1       (m1_if),
    .fx_wr    (fx_wr),
    .fx_rd    (fx_rd),
    .fx_waddr (fx_waddr),
    .fx_raddr (fx_raddr),
    .fx_data  (fx_data),
    .fx_q     (fx_q),
    .bus_busy (bus_busy)
  );

  // Environment slave: device id 1, registered read data, 0x00 for other ids.
  logic       slv_clear;
  logic [7:0] slv_mem [65536];
  always @(posedge clk_sys) begin
    if (slv_clear) begin
      for (int i = 0; i < 65536; i++) slv_mem[i] <= 8'(i) ^ 8'h01;
    end else if (fx_wr && fx_waddr[21:16] == 6'd1) begin
      slv_mem[fx_waddr[15:0]] <= fx_data;
    end
    fx_q <= (fx_rd && fx_raddr[21:16] == 6'd1) ? slv_mem[fx_raddr[15:0]] : 8'h00;
  end

  // Reference model state.
  logic [7:0]  ref_mem [65536];
  bit          last_m;
  bit          p_we [2];
  logic [21:0] p_addr [2];
  int          p_len [2];
  logic [7:0]  p_wd [2][17];
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] flags(input int m);
    if (m == 0) return {m0_if.gnt, m0_if.wack, m0_if.rvalid, m0_if.done};
    return {m1_if.gnt, m1_if.wack, m1_if.rvalid, m1_if.done};
  endfunction

  function automatic logic [7:0] rdata_of(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  task automatic set_wdata(input int m, input logic [7:0] d);
    if (m == 0) m0_if.wdata = d;
    else        m1_if.wdata = d;
  endtask

  task automatic set_wd(input int m, input bit rnd, input logic [7:0] base);
    for (int j = 0; j < 17; j++) p_wd[m][j] = rnd ? 8'($urandom) : base + 8'(j);
  endtask

  task automatic post(input int m, input bit we, input logic [21:0] a, input int len);
    p_we[m]   = we;
    p_addr[m] = a;
    p_len[m]  = len;
    if (m == 0) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.addr = a; m0_if.len = LenW'(len);
      m0_if.wdata = p_wd[0][0];
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.addr = a; m1_if.len = LenW'(len);
      m1_if.wdata = p_wd[1][0];
    end
  endtask

  // Owner drops req and garbles its request fields; the burst must not notice.
  task automatic scramble(input int m);
    if (m == 0) begin
      m0_if.req = 1'b0; m0_if.addr = ~m0_if.addr; m0_if.len = ~m0_if.len; m0_if.we = ~m0_if.we;
    end else begin
      m1_if.req = 1'b0; m1_if.addr = ~m1_if.addr; m1_if.len = ~m1_if.len; m1_if.we = ~m1_if.we;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    #1;
    check_eq("rst_strobes", {fx_wr, fx_rd, bus_busy}, 0);
    check_eq("rst_flags", {flags(0), flags(1)}, 0);
    check_eq("rst_rdata", {rdata_of(0), rdata_of(1)}, 0);
    repeat (3) @(negedge clk_sys);
    check_eq("rst_hold", {flags(0), flags(1), fx_wr, fx_rd, bus_busy}, 0);
    rst_n  = 1'b1;
    last_m = 1'b1;
  endtask

  // Wait for the next grant and check the whole burst cycle by cycle (k = cycles after G).
  task automatic serve(input bit keep, input int abort_k);
    int          o, n, beat, kend, len;
    bit          we, got;
    logic [21:0] a;
    logic [7:0]  n_rdata;
    logic [3:0]  own, exp_flags;
    logic        prev_wack;
    logic [15:0] off;
    if (m0_if.req && m1_if.req) o = last_m ? 0 : 1;
    else                        o = m1_if.req ? 1 : 0;
    n   = 1 - o;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk_sys);
      got = m0_if.gnt | m1_if.gnt;
    end
    check_eq("gnt_seen", 32'(got), 1);
    if (!got) return;
    we      = p_we[o];
    a       = p_addr[o];
    len     = p_len[o];
    last_m  = (o == 1);
    n_rdata = rdata_of(n);
    if (we && a[21:16] == 6'd1)
      for (int j = 0; j <= len; j++) ref_mem[a[15:0] + 16'(j)] = p_wd[o][j];
    kend      = we ? len + 2 : len + 4;
    beat      = 0;
    prev_wack = 1'b0;
    for (int k = 0; k <= kend; k++) begin
      if (k > 0) @(negedge clk_sys);
      if (prev_wack) begin
        beat++;
        set_wdata(o, p_wd[o][beat]);
      end
      if (k == 1 && !keep) scramble(o);
      exp_flags = {k == 0, we && k <= len, !we && k >= 3 && k <= len + 3,
                   we ? (k == len + 1) : (k == len + 3)};
      own = flags(o);
      check_eq("own_flags", own, exp_flags);
      check_eq("other_flags", flags(n), 0);
      check_eq("other_rdata", rdata_of(n), n_rdata);
      check_eq("fx_wr", fx_wr, we && k >= 1 && k <= len + 1);
      check_eq("fx_rd", fx_rd, !we && k >= 1 && k <= len + 1);
      check_eq("bus_busy", bus_busy, k < kend);
      if (k >= 1 && k <= len + 1) begin
        off = a[15:0] + 16'(k - 1);
        if (we) begin
          check_eq("fx_waddr", fx_waddr, {a[21:16], off});
          check_eq("fx_data", fx_data, p_wd[o][k-1]);
        end else begin
          check_eq("fx_raddr", fx_raddr, {a[21:16], off});
        end
      end
      if (!we && k >= 3 && k <= len + 3) begin
        off = a[15:0] + 16'(k - 3);
        check_eq("rdata", rdata_of(o), (a[21:16] == 6'd1) ? ref_mem[off] : 8'h00);
      end
      prev_wack = own[2];
      if (k == abort_k) begin
        apply_reset();
        return;
      end
    end
    if (keep) set_wdata(o, p_wd[o][0]);
  endtask

  function automatic logic [21:0] rand_addr();
    logic [5:0]  dev;
    logic [15:0] off;
    dev = ($urandom_range(0, 3) == 0) ? 6'd2 : 6'd1;
    off = $urandom_range(0, 1) ? 16'hFFF8 + 16'($urandom_range(0, 15))
                               : 16'h0100 + 16'($urandom_range(0, 31));
    return {dev, off};
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int mode;
    rst_n     = 1'b0;
    slv_clear = 1'b1;
    m0_if.req = 1'b0; m0_if.we = 1'b0; m0_if.addr = '0; m0_if.len = '0; m0_if.wdata = '0;
    m1_if.req = 1'b0; m1_if.we = 1'b0; m1_if.addr = '0; m1_if.len = '0; m1_if.wdata = '0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i) ^ 8'h01;
    set_wd(0, 1'b0, 8'h00);
    set_wd(1, 1'b0, 8'h00);
    #2;
    check_eq("reset_strobes", {fx_wr, fx_rd, bus_busy, fx_waddr, fx_data}, 0);
    check_eq("reset_flags", {flags(0), flags(1), rdata_of(0), rdata_of(1)}, 0);
    repeat (2) @(negedge clk_sys);
    slv_clear = 1'b0;
    rst_n     = 1'b1;
    last_m    = 1'b1;
    @(negedge clk_sys);

    // Single read of the device-1 id register.
    post(0, 1'b0, 22'h010000, 0);
    serve(1'b0, -1);
    check_eq("id_read", m0_if.rdata, 8'h01);

    // m1 write burst then readback.
    set_wd(1, 1'b0, 8'hA0);
    post(1, 1'b1, 22'h010080, 3);
    serve(1'b0, -1);
    post(1, 1'b0, 22'h010080, 3);
    serve(1'b0, -1);
    check_eq("readback_last", m1_if.rdata, 8'hA3);

    // Simultaneous requests right after reset: m0, m1, m0.
    apply_reset();
    set_wd(0, 1'b1, 8'h00);
    set_wd(1, 1'b1, 8'h00);
    post(0, 1'b1, 22'h010300, 1);
    post(1, 1'b0, 22'h010300, 2);
    serve(1'b1, -1);
    serve(1'b1, -1);
    serve(1'b1, -1);
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;

    // Offset wrap inside a read burst.
    post(0, 1'b0, 22'h01FFFE, 3);
    serve(1'b0, -1);

    // 8-beat write with owner req/addr changed after grant, then readback.
    set_wd(0, 1'b1, 8'h00);
    post(0, 1'b1, 22'h010200, 7);
    serve(1'b0, -1);
    post(0, 1'b0, 22'h010200, 7);
    serve(1'b0, -1);

    // Reset in the middle of a 5-beat read, then m1 is served normally.
    post(0, 1'b0, 22'h010010, 4);
    serve(1'b0, 2);
    @(negedge clk_sys);
    post(1, 1'b0, 22'h010010, 2);
    serve(1'b0, -1);

    // Random traffic, single and contending requests.
    for (int it = 0; it < 24; it++) begin
      mode = $urandom_range(0, 2);
      for (int mm = 0; mm < 2; mm++) begin
        if (mode == mm || mode == 2) begin
          set_wd(mm, 1'b1, 8'h00);
          post(mm, 1'($urandom_range(0, 1)), rand_addr(), $urandom_range(0, 15));
        end
      end
      serve(1'b0, -1);
      if (mode == 2) serve(1'b0, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
